// File: rtl/config_initiator.sv
// ============================================================================
// config_initiator
// ----------------------------------------------------------------------------
// Host-side initiator for the 64-bit configuration packet protocol. A config
// write or read command is turned into one protocol packet (op code, chip ID,
// address, data, magic number, odd parity) and handed to the tx UART. Reads
// then wait for the matching flagged reply coming back around the chip chain.
// Every command ends with a one-cycle resp_valid strobe carrying the read
// data, the responder's chip ID, or a timeout indication.
//
// Ports:
//   clk, reset        primary clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (cmd_ready is high only in IDLE)
//   cmd_read          1 = config read, 0 = config write
//   cmd_chip_id       target chip ID (GLOBAL_ID addresses every chip)
//   cmd_addr          register address
//   cmd_data          write data, ignored for reads
//   tx_data           packet for the tx UART, held until the next command
//   ld_tx_data        one-cycle load strobe to the tx UART
//   tx_busy           tx UART is sending
//   rx_data           word from the rx UART
//   rx_data_flag      level, high while an rx word is ready
//   resp_valid        one-cycle completion strobe
//   resp_data         read data (write data echoed for writes, 0 on timeout)
//   resp_chip_id      chip ID of the responder
//   resp_timeout      read timed out, qualified by resp_valid
//   bad_reply_count   saturating count of malformed words seen while waiting
//
// The packet field layout is fixed at 64 bits; WIDTH is kept as a parameter
// only so the port widths read naturally and must stay at 64.
// ============================================================================
module config_initiator #(
    parameter int          WIDTH           = 64,
    parameter int          GLOBAL_ID       = 255,
    parameter logic [31:0] MAGIC_NUMBER    = 32'h89504E47,
    parameter logic [1:0]  CONFIG_WRITE_OP = 2'b10,
    parameter logic [1:0]  CONFIG_READ_OP  = 2'b11,
    parameter int          TIMEOUT_CYCLES  = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_read,
    input  logic [7:0]       cmd_chip_id,
    input  logic [7:0]       cmd_addr,
    input  logic [7:0]       cmd_data,
    output logic [WIDTH-1:0] tx_data,
    output logic             ld_tx_data,
    input  logic             tx_busy,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_data_flag,
    output logic             resp_valid,
    output logic [7:0]       resp_data,
    output logic [7:0]       resp_chip_id,
    output logic             resp_timeout,
    output logic [15:0]      bad_reply_count
);

    // The timer only has to reach TIMEOUT_CYCLES-1, so clog2 bits suffice.
    localparam int                  TIMER_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]          GLOBAL_CHIP = 8'(GLOBAL_ID);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TX_START,
        TX_DRAIN,
        AWAIT_REPLY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Command fields captured at acceptance; the reply matcher and the write
    // completion both refer back to them.
    logic               lat_read;
    logic [7:0]         lat_chip_id;
    logic [7:0]         lat_addr;
    logic [7:0]         lat_data;

    logic [TIMER_W-1:0] timer;
    logic               rx_flag_prev;

    logic               cmd_accept;
    logic               rx_qualified;
    logic               rx_malformed;
    logic               rx_chip_ok;
    logic               rx_match;
    logic               timer_expired;
    logic               load_fire;
    logic               enter_done;

    // Assemble a request packet from command fields. Reads always carry a
    // zero data byte, and bit 62 (the reply flag) is clear on requests.
    function automatic logic [WIDTH-1:0] build_packet(
        input logic       is_read,
        input logic [7:0] chip_id,
        input logic [7:0] addr,
        input logic [7:0] data
    );
        logic [WIDTH-1:0] pkt;
        pkt          = '0;
        pkt[1:0]     = is_read ? CONFIG_READ_OP : CONFIG_WRITE_OP;
        pkt[9:2]     = chip_id;
        pkt[17:10]   = addr;
        pkt[25:18]   = is_read ? 8'h00 : data;
        pkt[57:26]   = MAGIC_NUMBER;
        pkt[63]      = ~^pkt[62:0];
        return pkt;
    endfunction

    assign cmd_ready  = (state == IDLE);
    assign cmd_accept = cmd_valid && cmd_ready;

    // An rx word is looked at once, on the rising edge of its flag, and only
    // while a reply is actually expected.
    assign rx_qualified = (state == AWAIT_REPLY) && rx_data_flag && !rx_flag_prev;

    // With odd parity the XOR over the whole word is 1 for a good word.
    assign rx_malformed = !(^rx_data) || (rx_data[57:26] != MAGIC_NUMBER);

    // A global read accepts a reply from whichever chip answers first.
    assign rx_chip_ok = (lat_chip_id == GLOBAL_CHIP) || (rx_data[9:2] == lat_chip_id);

    assign rx_match = rx_qualified && !rx_malformed &&
                      (rx_data[1:0] == CONFIG_READ_OP) &&
                      rx_data[62] &&
                      (rx_data[17:10] == lat_addr) &&
                      rx_chip_ok;

    assign timer_expired = (state == AWAIT_REPLY) && (timer == TIMER_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the decoded events that feed the registered
    // outputs. A match is tested before the timer so that a reply arriving
    // on the very last cycle still counts as a successful read.
    always_comb begin
        state_next = state;
        load_fire  = 1'b0;
        enter_done = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (!tx_busy) begin
                    load_fire  = 1'b1;
                    state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_busy) begin
                    state_next = TX_DRAIN;
                end
            end
            TX_DRAIN: begin
                if (!tx_busy) begin
                    if (lat_read) begin
                        state_next = AWAIT_REPLY;
                    end else begin
                        state_next = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            AWAIT_REPLY: begin
                if (rx_match || timer_expired) begin
                    state_next = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command capture. tx_data is only rewritten on acceptance so the tx
    // UART can read it at any time after the load strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_read    <= 1'b0;
            lat_chip_id <= 8'h00;
            lat_addr    <= 8'h00;
            lat_data    <= 8'h00;
            tx_data     <= '0;
        end else if (cmd_accept) begin
            lat_read    <= cmd_read;
            lat_chip_id <= cmd_chip_id;
            lat_addr    <= cmd_addr;
            lat_data    <= cmd_data;
            tx_data     <= build_packet(cmd_read, cmd_chip_id, cmd_addr, cmd_data);
        end
    end

    // Load strobe to the tx UART, one cycle per command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_tx_data <= 1'b0;
        end else begin
            ld_tx_data <= load_fire;
        end
    end

    // Reply timer: cleared while the request drains out of the tx UART, so it
    // starts from zero on the first cycle of the wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state == TX_DRAIN) begin
            timer <= '0;
        end else if (state == AWAIT_REPLY) begin
            timer <= timer + 1'b1;
        end
    end

    // Previous rx flag level for rising-edge detection. Tracked in every
    // state so a flag already high when the wait begins is not mistaken for
    // a fresh word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_flag_prev <= 1'b0;
        end else begin
            rx_flag_prev <= rx_data_flag;
        end
    end

    // Malformed-reply counter; sticks at all ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_reply_count <= 16'h0000;
        end else if (rx_qualified && rx_malformed && (bad_reply_count != 16'hFFFF)) begin
            bad_reply_count <= bad_reply_count + 16'd1;
        end
    end

    // Response registers. They change only when DONE is entered and then
    // hold, so software can read them well after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid   <= 1'b0;
            resp_data    <= 8'h00;
            resp_chip_id <= 8'h00;
            resp_timeout <= 1'b0;
        end else begin
            resp_valid <= enter_done;
            if (enter_done) begin
                if (state == AWAIT_REPLY) begin
                    if (rx_match) begin
                        resp_data    <= rx_data[25:18];
                        resp_chip_id <= rx_data[9:2];
                        resp_timeout <= 1'b0;
                    end else begin
                        resp_data    <= 8'h00;
                        resp_chip_id <= lat_chip_id;
                        resp_timeout <= 1'b1;
                    end
                end else begin
                    resp_data    <= lat_data;
                    resp_chip_id <= lat_chip_id;
                    resp_timeout <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_config_initiator.sv
// ============================================================================
// tb_config_initiator
// ----------------------------------------------------------------------------
// Self-checking bench for config_initiator (TIMEOUT_CYCLES = 16). Commands are
// driven with a small tx UART emulation; read replies are injected from a
// queue. The expected packet, response and malformed-word count come from a
// protocol-level model working on the reply list and its arrival cycles.
// ============================================================================
module tb_config_initiator;

    localparam int          TMO   = 16;
    localparam logic [31:0] MAGIC = 32'h89504E47;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [7:0]  cmd_chip_id;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [63:0] tx_data;
    logic        ld_tx_data;
    logic        tx_busy;
    logic [63:0] rx_data;
    logic        rx_data_flag;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [7:0]  resp_chip_id;
    logic        resp_timeout;
    logic [15:0] bad_reply_count;

    int checks     = 0;
    int failures   = 0;
    int ld_count   = 0;
    int resp_count = 0;
    int exp_bad    = 0;

    logic [63:0] reply_words[$];
    int          reply_gap = 0;
    logic [63:0] exp_pkt;

    config_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_read        (cmd_read),
        .cmd_chip_id     (cmd_chip_id),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .tx_data         (tx_data),
        .ld_tx_data      (ld_tx_data),
        .tx_busy         (tx_busy),
        .rx_data         (rx_data),
        .rx_data_flag    (rx_data_flag),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_chip_id    (resp_chip_id),
        .resp_timeout    (resp_timeout),
        .bad_reply_count (bad_reply_count)
    );

    always #5 clk = ~clk;

    // Strobe counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (ld_tx_data) ld_count++;
        if (resp_valid) resp_count++;
    end

    // Hard stop in case something wedges the flow.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Protocol word: op, chip, addr, data, magic, reply flag, odd parity.
    function automatic logic [63:0] make_word(input logic [1:0] op, input logic f62,
                                              input logic [7:0] chip, input logic [7:0] addr,
                                              input logic [7:0] data, input logic [31:0] magic,
                                              input logic flip_parity);
        logic [63:0] w;
        w = {1'b0, f62, 4'b0000, magic, data, addr, chip, op};
        w[63] = ~^w[62:0];
        if (flip_parity) w[63] = ~w[63];
        return w;
    endfunction

    function automatic bit is_malformed(input logic [63:0] w);
        return ((^w) == 1'b0) || (w[57:26] != MAGIC);
    endfunction

    function automatic bit is_match(input logic [63:0] w, input logic [7:0] chip, input logic [7:0] addr);
        return (w[1:0] == 2'b11) && w[62] && (w[17:10] == addr) &&
               ((chip == 8'hFF) || (w[9:2] == chip));
    endfunction

    // Reply j arrives on clock edge reply_gap+2j+1 counted from the edge that
    // starts the wait; the wait times out on edge TMO.
    task automatic modelRead(input logic [7:0] chip, input logic [7:0] addr,
                             output int lat, output logic [7:0] data,
                             output logic [7:0] rchip, output bit to, output int bad_inc);
        int          qual_edge;
        logic [63:0] w;
        lat = TMO; data = 8'h00; rchip = chip; to = 1'b1; bad_inc = 0;
        for (int j = 0; j < reply_words.size(); j++) begin
            qual_edge = reply_gap + 2 * j + 1;
            w = reply_words[j];
            if (qual_edge > TMO) break;
            if (is_malformed(w)) begin
                bad_inc++;
            end else if (is_match(w, chip, addr)) begin
                lat = qual_edge; data = w[25:18]; rchip = w[9:2]; to = 1'b0;
                break;
            end
        end
    endtask

    // Present one command, then play the tx UART: optionally busy at accept,
    // busy for busy_len cycles after the load strobe. Returns on the falling
    // edge where tx_busy is released.
    task automatic issueCommand(input bit rd, input logic [7:0] chip, input logic [7:0] addr,
                                input logic [7:0] data, input int pre_busy, input int busy_len,
                                input bit hold_valid);
        int k;
        bit early;
        exp_pkt = make_word(rd ? 2'b11 : 2'b10, 1'b0, chip, addr, rd ? 8'h00 : data, MAGIC, 1'b0);
        @(negedge clk);
        cmd_read = rd; cmd_chip_id = chip; cmd_addr = addr; cmd_data = data;
        cmd_valid = 1'b1;
        tx_busy = (pre_busy > 0);
        checkOutput("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        if (!hold_valid) cmd_valid = 1'b0;
        checkOutput("tx_packet", tx_data, exp_pkt);
        checkOutput("cmd_ready_busy", cmd_ready, 0);
        checkOutput("ld_not_yet", ld_tx_data, 0);
        if (pre_busy > 0) begin
            early = 1'b0;
            repeat (pre_busy) begin
                @(negedge clk);
                if (ld_tx_data) early = 1'b1;
            end
            tx_busy = 1'b0;
            checkOutput("ld_withheld", early, 0);
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ld_tx_data && k < 20);
        checkOutput("ld_latency", k, 1);
        tx_busy = 1'b1;
        for (int i = 0; i < busy_len; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput("ld_single", ld_tx_data, 0);
        end
        tx_busy = 1'b0;
    endtask

    // Full transaction: command, reply injection from reply_words, and all
    // response checks against the model.
    task automatic applyStimulus(input bit rd, input logic [7:0] chip, input logic [7:0] addr,
                                 input logic [7:0] data, input int pre_busy, input int busy_len,
                                 input bit hold_valid);
        int         ld0, wi, nresp, lat, exp_lat, bad_inc;
        bit         seen, ready_bad, exp_to, flag_used;
        logic [7:0] got_data, got_chip, exp_data, exp_chip;
        logic       got_to;
        ld0 = ld_count;
        if (rd) begin
            modelRead(chip, addr, exp_lat, exp_data, exp_chip, exp_to, bad_inc);
        end else begin
            exp_lat = 0; exp_data = data; exp_chip = chip; exp_to = 1'b0; bad_inc = 0;
        end
        issueCommand(rd, chip, addr, data, pre_busy, busy_len, hold_valid);
        seen = 1'b0; ready_bad = 1'b0; nresp = 0; lat = -1; wi = 0;
        got_data = 8'h00; got_chip = 8'h00; got_to = 1'b0;
        flag_used = (reply_words.size() > 0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                nresp++;
                if (!seen) begin
                    seen = 1'b1; lat = n;
                    got_data = resp_data; got_chip = resp_chip_id; got_to = resp_timeout;
                    if (hold_valid) cmd_valid = 1'b0;
                end
            end else if (!seen && cmd_ready) begin
                ready_bad = 1'b1;
            end
            if (wi < reply_words.size() && n >= reply_gap) begin
                if (((n - reply_gap) % 2) == 0) begin
                    rx_data = reply_words[wi];
                    rx_data_flag = 1'b1;
                end else begin
                    rx_data_flag = 1'b0;
                    wi++;
                end
            end
        end
        cmd_valid = 1'b0;
        if (flag_used) rx_data_flag = 1'b0;
        exp_bad = (exp_bad + bad_inc > 65535) ? 65535 : exp_bad + bad_inc;
        checkOutput("resp_seen", seen, 1);
        checkOutput("resp_once", nresp, 1);
        checkOutput("resp_latency", lat, exp_lat);
        checkOutput("resp_timeout", got_to, exp_to);
        checkOutput("resp_data", got_data, exp_data);
        if (!exp_to) checkOutput("resp_chip_id", got_chip, exp_chip);
        checkOutput("ready_low_in_op", ready_bad, 0);
        checkOutput("ld_pulses", ld_count - ld0, 1);
        checkOutput("bad_count", bad_reply_count, exp_bad);
        checkOutput("tx_hold", tx_data, exp_pkt);
    endtask

    // Random reply list mixing matches, malformed words and well-formed
    // words that must be ignored.
    task automatic genReplies(input logic [7:0] chip, input logic [7:0] addr, input int n);
        logic [7:0] d, rc;
        reply_words.delete();
        for (int i = 0; i < n; i++) begin
            d  = 8'($urandom);
            rc = (chip == 8'hFF) ? 8'($urandom) : chip;
            case ($urandom_range(0, 6))
                0: reply_words.push_back(make_word(2'b11, 1'b1, rc, addr, d, MAGIC, 1'b0));
                1: reply_words.push_back(make_word(2'b11, 1'b1, rc, addr, d, MAGIC, 1'b1));
                2: reply_words.push_back(make_word(2'b11, 1'b1, rc, addr, d, MAGIC ^ 32'h0001_0000, 1'b0));
                3: reply_words.push_back(make_word(2'b11, 1'b1, rc, addr ^ 8'($urandom_range(1, 255)), d, MAGIC, 1'b0));
                4: reply_words.push_back(make_word(2'b11, 1'b1, chip ^ 8'($urandom_range(1, 255)), addr, d, MAGIC, 1'b0));
                5: reply_words.push_back(make_word(2'b10, 1'b1, rc, addr, d, MAGIC, 1'b0));
                default: reply_words.push_back(make_word(2'b11, 1'b0, rc, addr, d, MAGIC, 1'b0));
            endcase
        end
    endtask

    initial begin
        int   rc0;
        bit   rd;
        logic [7:0] ch, ad, da;

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_chip_id = 8'h00; cmd_addr = 8'h00; cmd_data = 8'h00;
        tx_busy = 1'b0; rx_data = 64'h0; rx_data_flag = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_tx_data", tx_data, 64'h0);
        checkOutput("rst_ld", ld_tx_data, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_data", resp_data, 0);
        checkOutput("rst_resp_chip", resp_chip_id, 0);
        checkOutput("rst_resp_timeout", resp_timeout, 0);
        checkOutput("rst_bad_count", bad_reply_count, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;

        $display("[TB] basic write");
        reply_words.delete(); reply_gap = 0;
        applyStimulus(1'b0, 8'h12, 8'h05, 8'hA5, 0, 2, 1'b0);

        $display("[TB] basic read");
        reply_words.delete();
        reply_words.push_back(make_word(2'b11, 1'b1, 8'h03, 8'h10, 8'h5C, MAGIC, 1'b0));
        applyStimulus(1'b1, 8'h03, 8'h10, 8'h77, 0, 3, 1'b0);

        $display("[TB] read with bad parity and wrong address ahead of the reply");
        reply_words.delete();
        reply_words.push_back(make_word(2'b11, 1'b1, 8'h03, 8'h10, 8'h99, MAGIC, 1'b1));
        reply_words.push_back(make_word(2'b11, 1'b1, 8'h03, 8'h11, 8'h66, MAGIC, 1'b0));
        reply_words.push_back(make_word(2'b11, 1'b1, 8'h03, 8'h10, 8'hC3, MAGIC, 1'b0));
        applyStimulus(1'b1, 8'h03, 8'h10, 8'h00, 0, 1, 1'b0);

        $display("[TB] read timeout with rx flag held high");
        reply_words.delete();
        @(negedge clk);
        rx_data = make_word(2'b11, 1'b1, 8'h04, 8'h20, 8'h01, MAGIC, 1'b1);
        rx_data_flag = 1'b1;
        applyStimulus(1'b1, 8'h04, 8'h20, 8'h00, 0, 2, 1'b0);
        rx_data_flag = 1'b0;

        $display("[TB] tx busy at accept with command held");
        applyStimulus(1'b0, 8'h21, 8'h42, 8'h3C, 3, 2, 1'b1);

        $display("[TB] reply on the timeout cycle");
        reply_words.delete();
        reply_words.push_back(make_word(2'b11, 1'b1, 8'h0A, 8'h0B, 8'hE1, MAGIC, 1'b0));
        reply_gap = TMO - 1;
        applyStimulus(1'b1, 8'h0A, 8'h0B, 8'h00, 0, 1, 1'b0);
        reply_gap = 0;

        $display("[TB] global read, first reply wins");
        reply_words.delete();
        reply_words.push_back(make_word(2'b11, 1'b1, 8'h07, 8'h20, 8'h11, MAGIC, 1'b0));
        reply_words.push_back(make_word(2'b11, 1'b1, 8'h09, 8'h20, 8'h22, MAGIC, 1'b0));
        applyStimulus(1'b1, 8'hFF, 8'h20, 8'h00, 0, 2, 1'b0);

        $display("[TB] reset during reply wait");
        reply_words.delete();
        issueCommand(1'b1, 8'h05, 8'h30, 8'h00, 0, 2, 1'b0);
        @(negedge clk);
        rx_data = make_word(2'b11, 1'b1, 8'h05, 8'h30, 8'h44, MAGIC ^ 32'h8000_0000, 1'b0);
        rx_data_flag = 1'b1;
        @(negedge clk);
        rx_data_flag = 1'b0;
        @(negedge clk);
        exp_bad = (exp_bad + 1 > 65535) ? 65535 : exp_bad + 1;
        checkOutput("bad_before_reset", bad_reply_count, exp_bad);
        rc0 = resp_count;
        reset = 1'b1;
        #1;
        exp_bad = 0;
        checkOutput("mid_rst_tx_data", tx_data, 64'h0);
        checkOutput("mid_rst_resp_valid", resp_valid, 0);
        checkOutput("mid_rst_ld", ld_tx_data, 0);
        checkOutput("mid_rst_resp_data", resp_data, 0);
        checkOutput("mid_rst_bad_count", bad_reply_count, 0);
        checkOutput("mid_rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rx_data = make_word(2'b11, 1'b1, 8'h05, 8'h30, 8'h44, MAGIC, 1'b0);
        rx_data_flag = 1'b1;
        @(negedge clk);
        rx_data_flag = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("post_rst_no_resp", resp_count - rc0, 0);
        checkOutput("post_rst_bad_count", bad_reply_count, 0);
        checkOutput("post_rst_cmd_ready", cmd_ready, 1);

        $display("[TB] random transactions");
        for (int t = 0; t < 30; t++) begin
            rd = 1'($urandom_range(0, 1));
            ch = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
            ad = 8'($urandom);
            da = 8'($urandom);
            reply_gap = 0;
            if (rd) genReplies(ch, ad, int'($urandom_range(0, 5)));
            else reply_words.delete();
            applyStimulus(rd, ch, ad, da, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                          1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_initiator.md
Name: config_initiator

Overview:
- Host-side initiator for the 64-bit configuration packet protocol.
- Accepts config write/read commands and serializes each into a protocol packet with magic number and odd parity.
- Hands the packet to the tx UART, and for reads waits for the matching flagged reply from the chip chain.
- Reports the read data, a timeout, or completion on a one-cycle response strobe.

Parameters:
- WIDTH, 64, packet width.
- GLOBAL_ID, 255, broadcast chip ID.
- MAGIC_NUMBER, 32'h89504E47, value placed in / checked at bits [57:26].
- CONFIG_WRITE_OP, 2'b10, op code, bits [1:0].
- CONFIG_READ_OP, 2'b11, op code, bits [1:0].
- TIMEOUT_CYCLES, 4096, reply wait limit in clocks; minimum 2.

Ports:
- clk  input  1  primary clock
- reset  input  1  asynchronous reset, active high
- cmd_valid  input  1  command present
- cmd_ready  output  1  high when command can be accepted
- cmd_read  input  1  1 = config read, 0 = config write
- cmd_chip_id  input  8  target chip ID
- cmd_addr  input  8  register address
- cmd_data  input  8  write data (ignored for reads)
- tx_data  output  WIDTH  packet to tx uart
- ld_tx_data  output  1  one-cycle load strobe to tx uart
- tx_busy  input  1  tx uart sending
- rx_data  input  WIDTH  word from rx uart
- rx_data_flag  input  1  level; high while rx word is ready
- resp_valid  output  1  one-cycle completion strobe
- resp_data  output  8  read data
- resp_chip_id  output  8  chip ID of responder
- resp_timeout  output  1  read timed out; qualified by resp_valid
- bad_reply_count  output  16  saturating count of malformed rx words seen while awaiting a reply

Behaviour:
- Reset: every output is 0, including tx_data and all counters, and state = IDLE.
  - Exception: cmd_ready is combinational (state==IDLE), so it reads 1 after reset.
  - Reset asserted mid-operation aborts to IDLE with no resp_valid.
- Packet build, registered into tx_data on acceptance:
  - [1:0] op, [9:2] chip_id, [17:10] addr, [25:18] data (0 for reads).
  - [57:26] MAGIC_NUMBER, [61:58] 0, [62] 0.
  - [63] = ~^[62:0] (odd parity).
- tx_data holds its value until the next accepted command.
- Handshake: a command is accepted on the clk edge where cmd_valid && cmd_ready; fields are latched. Commands presented outside IDLE are not accepted.
- States:
  - IDLE: on accept -> LOAD.
  - LOAD: if !tx_busy, drive ld_tx_data=1 for exactly one cycle and go to TX_START; else stay in LOAD.
  - TX_START: wait for tx_busy=1, then go to TX_DRAIN.
  - TX_DRAIN: wait for tx_busy=0.
    - Write, or read with chip_id==GLOBAL_ID handled below: write -> DONE.
    - Read -> AWAIT_REPLY, with the timer cleared.
  - AWAIT_REPLY: the timer increments every cycle. An rx word is qualified only on a rising edge of rx_data_flag (registered previous value). A qualified word:
    - Malformed (parity wrong OR magic != MAGIC_NUMBER): bad_reply_count++ (saturates at 16'hFFFF); stay in AWAIT_REPLY.
    - Match: op==CONFIG_READ_OP, bit62==1, addr field==latched addr, and chip field==latched chip_id (any chip if latched chip_id==GLOBAL_ID). Capture [25:18] into resp_data and [9:2] into resp_chip_id; -> DONE.
    - Other well-formed word: ignored.
    - If the timer reaches TIMEOUT_CYCLES-1 with no match: resp_timeout=1, resp_data=0, -> DONE.
    - A match and a timeout in the same cycle: the match wins, resp_timeout=0.
  - DONE: resp_valid=1 for one cycle -> IDLE. For writes, resp_chip_id = latched chip_id and resp_data = latched data.
- Response register updates:
  - resp_data, resp_chip_id and resp_timeout update only on entry to DONE and hold until the next DONE.
  - resp_valid is otherwise 0.
- Global read: completes on the first matching reply. Later replies are ignored.
- rx edges outside AWAIT_REPLY are ignored, and do not count toward bad_reply_count.
- Minimum latency, write with tx_busy idle: accept edge -> ld_tx_data 1 cycle later -> resp_valid 1 cycle after tx_busy falls.
- All outputs except cmd_ready are registered.

Test Plan:
- Write chip 0x12, addr 0x05, data 0xA5, tx_busy low -> one ld_tx_data pulse with tx_data[1:0]=2'b10, [9:2]=0x12, [17:10]=0x05, [25:18]=0xA5, [57:26]=0x89504E47, [63]=~^[62:0]. After the tx_busy high/low sequence, a single resp_valid with resp_timeout=0.
- Read chip 0x03, addr 0x10; inject reply op=11, bit62=1, chip 0x03, addr 0x10, data 0x5C, valid parity/magic -> resp_valid, resp_data=0x5C, resp_chip_id=0x03, resp_timeout=0.
- Read pending; inject a word with a flipped parity bit, then a word with addr 0x11, then the correct reply -> bad_reply_count=1, no early resp_valid, final resp_data correct.
- Read with no reply, TIMEOUT_CYCLES=16 -> resp_valid with resp_timeout=1, resp_data=0, exactly 16 cycles after entering AWAIT_REPLY. Hold rx_data_flag high across the whole wait -> no extra qualification.
- tx_busy held high at command accept -> ld_tx_data is withheld until tx_busy falls. cmd_valid held during the operation -> cmd_ready=0, no second accept until after resp_valid.
- Assert reset during AWAIT_REPLY -> all outputs 0, no resp_valid; a reply arriving afterwards is ignored and bad_reply_count stays 0.
